// File: rtl/cellrv32_wb_sram.sv
// Wishbone slave bridging a power-of-two address window onto an asynchronous 16-bit SRAM.
// Each 32-bit access becomes up to two halfword cycles (SETUP/STROBE/HOLD) with programmable wait states.
module cellrv32_wb_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h9000_0000,
  parameter int          SIZE_BYTES  = 1048576,
  parameter int          WAIT_STATES = 2,
  parameter bit          PIPE_MODE   = 1'b0,
  parameter bit          PRIV_ONLY   = 1'b0,
  localparam int         AW          = $clog2(SIZE_BYTES)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [2:0]    wb_tag_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_stb_i,
  input  logic          wb_cyc_i,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [AW-2:0] sram_addr_o,
  output logic [15:0]   sram_dq_o,
  input  logic [15:0]   sram_dq_i,
  output logic          sram_dq_oe_o,
  output logic          sram_ce_n_o,
  output logic          sram_oe_n_o,
  output logic          sram_we_n_o,
  output logic          sram_lb_n_o,
  output logic          sram_ub_n_o
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  state_t        state;
  logic [AW-1:2] adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          hi_q;
  logic          hi_pend;
  logic          abort_q;
  logic [3:0]    cnt;
  logic [31:0]   rdata;

  logic hit;
  logic priv_ok;
  logic lo_req;
  logic hi_req;
  logic unused_bits;

  assign hit     = (wb_adr_i[31:AW] == BASE_ADDR[31:AW]);
  assign priv_ok = !PRIV_ONLY || wb_tag_i[0];
  assign lo_req  = |wb_sel_i[1:0];
  assign hi_req  = |wb_sel_i[3:2];

  // Fetch flag and byte offset carry no meaning for a word-organised halfword SRAM;
  // stb is only sampled in IDLE, so classic and pipelined masters share one datapath.
  assign unused_bits = ^{wb_tag_i[2:1], wb_adr_i[1:0], PIPE_MODE};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      hi_q         <= 1'b0;
      hi_pend      <= 1'b0;
      abort_q      <= 1'b0;
      cnt          <= '0;
      rdata        <= '0;
      wb_dat_o     <= '0;
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      sram_addr_o  <= '0;
      sram_dq_o    <= '0;
      sram_dq_oe_o <= 1'b0;
      sram_ce_n_o  <= 1'b1;
      sram_oe_n_o  <= 1'b1;
      sram_we_n_o  <= 1'b1;
      sram_lb_n_o  <= 1'b1;
      sram_ub_n_o  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            adr_q   <= wb_adr_i[AW-1:2];
            dat_q   <= wb_dat_i;
            sel_q   <= wb_sel_i;
            we_q    <= wb_we_i;
            rdata   <= '0;
            abort_q <= 1'b0;
            if (!hit || !priv_ok) begin
              wb_err_o <= 1'b1;
              state    <= RESP;
            end else if (wb_sel_i == 4'b0000) begin
              wb_ack_o <= 1'b1;
              wb_dat_o <= '0;
              state    <= RESP;
            end else begin
              // Start with the low halfword when any low lane is enabled, else go straight to HI.
              state        <= SETUP;
              hi_q         <= !lo_req;
              hi_pend      <= lo_req && hi_req;
              sram_ce_n_o  <= 1'b0;
              sram_addr_o  <= {wb_adr_i[AW-1:2], !lo_req};
              sram_lb_n_o  <= lo_req ? ~wb_sel_i[0] : ~wb_sel_i[2];
              sram_ub_n_o  <= lo_req ? ~wb_sel_i[1] : ~wb_sel_i[3];
              sram_dq_oe_o <= wb_we_i;
              if (wb_we_i) begin
                sram_dq_o <= lo_req ? wb_dat_i[15:0] : wb_dat_i[31:16];
              end
            end
          end
        end

        SETUP: begin
          state <= STROBE;
          cnt   <= 4'(WAIT_STATES);
          if (!wb_cyc_i) begin
            abort_q <= 1'b1;
          end
          if (we_q) begin
            sram_we_n_o <= 1'b0;
          end else begin
            sram_oe_n_o <= 1'b0;
          end
        end

        STROBE: begin
          if (!wb_cyc_i) begin
            abort_q <= 1'b1;
          end
          // Read data is sampled on the same edge that releases oe_n, while the SRAM still drives it.
          if (cnt == 4'd0) begin
            state       <= HOLD;
            sram_we_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            if (!we_q) begin
              if (hi_q) begin
                rdata[31:16] <= sram_dq_i;
              end else begin
                rdata[15:0] <= sram_dq_i;
              end
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        HOLD: begin
          if (!wb_cyc_i || abort_q) begin
            state        <= IDLE;
            sram_ce_n_o  <= 1'b1;
            sram_dq_oe_o <= 1'b0;
            sram_lb_n_o  <= 1'b1;
            sram_ub_n_o  <= 1'b1;
          end else if (hi_pend) begin
            state       <= SETUP;
            hi_q        <= 1'b1;
            hi_pend     <= 1'b0;
            sram_addr_o <= {adr_q, 1'b1};
            sram_lb_n_o <= ~sel_q[2];
            sram_ub_n_o <= ~sel_q[3];
            if (we_q) begin
              sram_dq_o <= dat_q[31:16];
            end
          end else begin
            state        <= RESP;
            wb_ack_o     <= 1'b1;
            wb_dat_o     <= rdata;
            sram_ce_n_o  <= 1'b1;
            sram_dq_oe_o <= 1'b0;
            sram_lb_n_o  <= 1'b1;
            sram_ub_n_o  <= 1'b1;
          end
        end

        RESP: begin
          state    <= IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          wb_dat_o <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
